// File: rtl/data_mem_responder_if.sv
// Multi-channel valid/ready data-memory bus plus the host preload port.
// The gpu side uses the master modport; the memory responder uses the slave modport.
interface data_mem_responder_if #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4
);
  logic [NUM_CHANNELS-1:0] mem_read_valid;
  logic [ADDR_BITS-1:0]    mem_read_address  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] mem_read_ready;
  logic [DATA_BITS-1:0]    mem_read_data     [NUM_CHANNELS];

  logic [NUM_CHANNELS-1:0] mem_write_valid;
  logic [ADDR_BITS-1:0]    mem_write_address [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    mem_write_data    [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] mem_write_ready;

  logic                    load_enable;
  logic [ADDR_BITS-1:0]    load_address;
  logic [DATA_BITS-1:0]    load_data;

  modport master (
    output mem_read_valid, mem_read_address,
    input  mem_read_ready, mem_read_data,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_write_ready,
    output load_enable, load_address, load_data
  );

  modport slave (
    input  mem_read_valid, mem_read_address,
    output mem_read_ready, mem_read_data,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_write_ready,
    input  load_enable, load_address, load_data
  );
endinterface

// File: rtl/data_mem_responder.sv
// Memory-side responder: per-channel read and write FSMs (IDLE -> WAIT -> RESPOND)
// answering after a fixed LATENCY, backed by a preloadable storage array.
module data_mem_responder #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int LATENCY      = 2,
  parameter int WRITE_ENABLE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  data_mem_responder_if.slave   bus
);
  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_e;

  logic [DATA_BITS-1:0]    mem_q [DEPTH];
  logic [NUM_CHANNELS-1:0] rd_ready;
  logic [NUM_CHANNELS-1:0] wr_ready;
  logic [NUM_CHANNELS-1:0] wr_commit;
  logic [ADDR_BITS-1:0]    wr_addr [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    wr_data [NUM_CHANNELS];

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_rd
    state_e               state_q;
    logic [3:0]           cnt_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic                 ready_q;
    logic [DATA_BITS-1:0] data_q;

    // NOTE: sequential state uses non-blocking assignments only, so every FSM
    // and the storage array see the same pre-edge values at each clock.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        addr_q  <= '0;
        ready_q <= 1'b0;
        data_q  <= '0;
      end else begin
        unique case (state_q)
          IDLE: if (bus.mem_read_valid[c]) begin
            addr_q  <= bus.mem_read_address[c];
            cnt_q   <= CNT_INIT;
            state_q <= WAIT;
          end
          WAIT: if (cnt_q == 4'd0) begin
            data_q  <= mem_q[addr_q];
            ready_q <= 1'b1;
            state_q <= RESPOND;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
          RESPOND: if (!bus.mem_read_valid[c]) begin
            ready_q <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end

    assign rd_ready[c]          = ready_q;
    assign bus.mem_read_data[c] = data_q;
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_wr
    if (WRITE_ENABLE != 0) begin : g_on
      state_e               state_q;
      logic [3:0]           cnt_q;
      logic [ADDR_BITS-1:0] addr_q;
      logic [DATA_BITS-1:0] data_q;
      logic                 ready_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          state_q <= IDLE;
          cnt_q   <= '0;
          addr_q  <= '0;
          data_q  <= '0;
          ready_q <= 1'b0;
        end else begin
          unique case (state_q)
            IDLE: if (bus.mem_write_valid[c]) begin
              addr_q  <= bus.mem_write_address[c];
              data_q  <= bus.mem_write_data[c];
              cnt_q   <= CNT_INIT;
              state_q <= WAIT;
            end
            WAIT: if (cnt_q == 4'd0) begin
              ready_q <= 1'b1;
              state_q <= RESPOND;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
            RESPOND: if (!bus.mem_write_valid[c]) begin
              ready_q <= 1'b0;
              state_q <= IDLE;
            end
            default: state_q <= IDLE;
          endcase
        end
      end

      // Derived from registered state, so an asynchronous reset during WAIT
      // suppresses the commit immediately.
      assign wr_commit[c] = (state_q == WAIT) && (cnt_q == 4'd0);
      assign wr_addr[c]   = addr_q;
      assign wr_data[c]   = data_q;
      assign wr_ready[c]  = ready_q;
    end else begin : g_off
      assign wr_commit[c] = 1'b0;
      assign wr_addr[c]   = '0;
      assign wr_data[c]   = '0;
      assign wr_ready[c]  = 1'b0;
    end
  end

  // NOTE: the storage array has no reset so it maps onto block RAM and keeps
  // preloaded contents across a reset; within this block the last non-blocking
  // write wins, giving load < channel 0 < ... < highest channel priority.
  always_ff @(posedge clk) begin
    if (bus.load_enable) mem_q[bus.load_address] <= bus.load_data;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (wr_commit[c]) mem_q[wr_addr[c]] <= wr_data[c];
    end
  end

  assign bus.mem_read_ready  = rd_ready;
  assign bus.mem_write_ready = wr_ready;
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Synthesizable memory-side responder for the multi-channel valid/ready data-memory interface that the gpu top level drives outward. It owns a 2^ADDR_BITS x DATA_BITS storage array and services each channel's read and write requests after a fixed LATENCY. It replaces the behavioural testbench memory in simulation and in FPGA bring-up. A load port lets the host preload contents before kernel start.

Parameters:
ADDR_BITS, 8, address width; storage depth = 2^ADDR_BITS
DATA_BITS, 8, word width
NUM_CHANNELS, 4, independent request channels
LATENCY, 2, cycles from request acceptance to ready; legal range 1..15
WRITE_ENABLE, 1, 0 = read-only responder; write ports ignored

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
mem_read_valid  in  [NUM_CHANNELS-1:0]  per-channel read request
mem_read_address  in  [ADDR_BITS-1:0] x NUM_CHANNELS (unpacked)  read address
mem_read_ready  out  [NUM_CHANNELS-1:0]  read data valid / request done
mem_read_data  out  [DATA_BITS-1:0] x NUM_CHANNELS (unpacked)  read data
mem_write_valid  in  [NUM_CHANNELS-1:0]  per-channel write request
mem_write_address  in  [ADDR_BITS-1:0] x NUM_CHANNELS  write address
mem_write_data  in  [DATA_BITS-1:0] x NUM_CHANNELS  write data
mem_write_ready  out  [NUM_CHANNELS-1:0]  write committed
load_enable  in  1  host preload strobe
load_address  in  [ADDR_BITS-1:0]  preload address
load_data  in  [DATA_BITS-1:0]  preload data

Behaviour:
- Reset (reset==0, async): all read and write FSMs go to IDLE. All mem_read_ready, mem_write_ready and mem_read_data clear to 0. Storage contents are not cleared. A reset asserted mid-request abandons it with no write commit.
- Each channel has two independent FSMs, one for read and one for write, with states IDLE -> WAIT -> RESPOND -> IDLE. Read and write on the same channel may run concurrently.
- IDLE: if valid is sampled high, capture the address (and the write data) and load counter = LATENCY-1.
  - If LATENCY==1, go directly to the commit.
  - Otherwise go to WAIT.
- WAIT: decrement the counter. Changes to address or data during WAIT are ignored because the captured values are used. When the counter reaches 0, commit on the next edge.
- Commit edge:
  - Read: mem_read_data <= mem[addr], ready <= 1, enter RESPOND.
  - Write: mem[addr] <= data, ready <= 1, enter RESPOND.
  - Ready therefore rises exactly LATENCY cycles after the edge at which valid was first sampled.
- RESPOND: hold ready=1 and hold read_data stable while valid stays high. On the first edge where valid is sampled low, ready <= 0 and return to IDLE. A new request is accepted no earlier than the following edge.
- mem_read_data retains its last value after ready falls and is only updated on a read commit.
- Valid dropping during WAIT: the request still completes. Ready pulses for one cycle, then the FSM returns to IDLE.
- Write collision (same address, same edge) priority: highest channel index wins among channel writes; any channel write beats load.
- Read/write same address, same edge: the read returns the old data (read-before-write).
- load_enable writes load_data to mem[load_address] on any edge, independent of the FSMs.
- WRITE_ENABLE==0: write FSMs are not generated, mem_write_ready is constant 0, and only the load port modifies storage.

Test Plan:
- Latency: preload mem[0x10]=0xAB; ch0 read 0x10 at edge N (LATENCY=2) -> read_ready[0] rises at N+2 with data 0xAB and holds while valid is high; drop valid -> ready falls at the next edge.
- Concurrent channels: ch1 writes 0x5A to 0x20 while ch2 reads 0x21 (preloaded 0x11) at the same edge -> both readies rise together; a later read of 0x20 returns 0x5A.
- Collisions: ch0 writes 0x01 and ch3 writes 0x03 to 0x30 at the same edge, with load_enable writing 0x77 to 0x30 on the commit edge -> mem[0x30]=0x03. A same-edge read of 0x30 returns the prior value.
- Address capture: ch1 read 0x40 issued, address changed to 0x41 during WAIT -> data returned is mem[0x40].
- Reset mid-request: write issued, reset pulled low during WAIT -> readies=0, read_data=0, target address unchanged, channel accepts a new request after release.
- Variants: LATENCY=1 -> ready one cycle after acceptance. WRITE_ENABLE=0 -> write_valid held high never produces write_ready and storage is unchanged.
